// File: rtl/issue_drain_ctrl.sv
// Issue-stage holding slot: issues one decoded instruction at a time,
// gated by the in-flight counter flags, with drain for barrier-class ops.
module issue_drain_ctrl #(
  parameter int INSTR_WIDTH     = 32,
  parameter int WFID_WIDTH      = 6,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic [WFID_WIDTH-1:0]      in_wfid,
  input  logic                       in_drain_req,
  input  logic                       flush,
  input  logic                       max_inflight_instr_flag,
  input  logic                       no_inflight_instr_flag,
  input  logic                       fu_ready,
  output logic                       out_valid,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [WFID_WIDTH-1:0]      out_wfid,
  output logic                       issued_en,
  output logic                       drain_active,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t                     r_state;
  state_t                     w_next;
  logic [INSTR_WIDTH-1:0]     r_instr;
  logic [WFID_WIDTH-1:0]      r_wfid;
  logic                       r_drain;
  logic [STALL_CNT_WIDTH-1:0] r_stall;

  logic w_capture;
  logic w_busy;
  logic w_issue;
  logic w_stall_inc;

  assign w_busy      = (r_state == S_HOLD) || (r_state == S_DRAIN);
  assign w_capture   = in_valid & in_ready & ~flush;
  assign w_issue     = out_valid & fu_ready & ~flush;
  assign w_stall_inc = w_busy & ~w_issue & ~flush & ~(&r_stall);

  // out_valid looks only at state and flags, never at fu_ready
  always_comb begin
    w_next       = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    drain_active = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (w_capture)
          w_next = in_drain_req ? S_DRAIN : S_HOLD;
      end
      S_HOLD: begin
        out_valid = ~max_inflight_instr_flag;
        if (flush || w_issue)
          w_next = S_IDLE;
      end
      S_DRAIN: begin
        out_valid    = no_inflight_instr_flag;
        drain_active = 1'b1;
        if (flush || w_issue)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_wfid  <= '0;
      r_drain <= 1'b0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_instr <= in_instr;
        r_wfid  <= in_wfid;
        r_drain <= in_drain_req;
      end else if (w_busy && flush) begin
        r_instr <= '0;
        r_wfid  <= '0;
        r_drain <= 1'b0;
      end
      if (w_stall_inc)
        r_stall <= r_stall + 1'b1;
    end
  end

  assign issued_en   = w_issue;
  assign out_instr   = r_instr;
  assign out_wfid    = r_wfid;
  assign stall_count = r_stall;

  logic w_unused;
  assign w_unused = r_drain;

endmodule

// File: doc/issue_drain_ctrl.md
Name: issue_drain_ctrl

Overview:
- Issue-side partner of the in-flight instruction counter: it produces the issued_en pulse that the counter consumes, and it gates issue on the counter's max_inflight_instr_flag and no_inflight_instr_flag.
- Holds one decoded instruction and issues it to the functional-unit dispatch when the in-flight budget allows.
- Instructions marked drain_req (s_barrier, s_waitcnt-class) issue only once the pipeline holds no in-flight instructions.
- Sits between the decode/instruction buffer and the FU dispatch in the issue stage.

Parameters:
INSTR_WIDTH, 32, width of the instruction word carried through
WFID_WIDTH, 6, wavefront id width
STALL_CNT_WIDTH, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  decode offers an instruction
in_ready  output  1  block can capture an instruction this cycle
in_instr  input  INSTR_WIDTH  instruction word
in_wfid  input  WFID_WIDTH  wavefront id
in_drain_req  input  1  instruction requires an empty pipeline before issue
flush  input  1  discard the held instruction
max_inflight_instr_flag  input  1  counter is at 15 in-flight
no_inflight_instr_flag  input  1  counter is at 0 in-flight
fu_ready  input  1  dispatch accepts an instruction this cycle
out_valid  output  1  held instruction is eligible to issue
out_instr  output  INSTR_WIDTH  held instruction
out_wfid  output  WFID_WIDTH  held wavefront id
issued_en  output  1  one-cycle pulse per issued instruction, to the counter
drain_active  output  1  waiting in DRAIN state
stall_count  output  STALL_CNT_WIDTH  saturating count of eligible-blocked cycles

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Held instr, wfid and drain flag clear to 0; stall_count clears to 0.
  - All outputs read 0 while rst is high, including in_ready.
- States: IDLE, HOLD, DRAIN. Registers update on the rising clk edge.
- in_ready = (state==IDLE) & ~rst. A capture occurs when in_valid & in_ready.
- IDLE:
  - On capture, latch in_instr, in_wfid and in_drain_req.
  - Next state is DRAIN if in_drain_req=1, else HOLD.
  - No capture: stay in IDLE.
- HOLD: out_valid = ~max_inflight_instr_flag.
- DRAIN: out_valid = no_inflight_instr_flag. drain_active=1 in DRAIN only.
- Issue:
  - issued_en = out_valid & fu_ready & ~flush; this is combinational and not registered.
  - On issue, next state is IDLE.
  - out_valid must never depend on fu_ready.
- Minimum spacing of 2 cycles between issues, by construction (issue, then IDLE capture). The counter updates on the edge after issued_en, so the flags seen in HOLD/DRAIN always include every prior issue. No back-to-back bypass is allowed; this guarantees the 4-bit counter never exceeds 15.
- out_instr and out_wfid present the held registers in every state; they are 0 after reset.
- flush:
  - In HOLD or DRAIN, flush forces IDLE and clears the held registers. No issued_en is produced, even if out_valid & fu_ready hold in the same cycle (flush wins).
  - In IDLE, flush blocks capture (in_ready stays 1, but the capture is ignored), so no instruction is latched that cycle.
- stall_count:
  - Increments by 1 each cycle the state is HOLD or DRAIN and issued_en=0 and flush=0.
  - Saturates at all-ones; it does not wrap.
  - Cleared only by reset.
- Retire activity is not seen directly; it arrives only through the flags. A flag change takes effect in the same cycle via out_valid.
- Reset asserted mid-HOLD/DRAIN: the held instruction is dropped with no issued_en, and the block is back in IDLE once rst deasserts.

Test Plan:
1. Reset then release; offer instr 0xDEADBEEF, wfid 5, drain_req=0; flags max=0, no=1; fu_ready=1 -> captured cycle 0, issued_en=1 with out_instr=0xDEADBEEF and out_wfid=5 in cycle 1, in_ready=1 again in cycle 2.
2. HOLD with max_inflight_instr_flag=1 for 10 cycles, then 0 -> out_valid=0 and issued_en=0 for 10 cycles, stall_count=10, issue on the first cycle the flag is 0.
3. drain_req=1 instruction while no_inflight_instr_flag=0 for 6 cycles -> drain_active=1, out_valid=0 for 6 cycles; flag rises -> issue that cycle, drain_active=0 the next cycle.
4. HOLD, out_valid=1, fu_ready=1, flush=1 in the same cycle -> issued_en=0, state IDLE, out_instr=0.
5. Continuous in_valid with fu_ready=1 and flags clear for 32 cycles -> exactly 16 issued_en pulses, never on consecutive cycles.
6. Force HOLD with max=1 for 70000 cycles (STALL_CNT_WIDTH=16) -> stall_count holds at 0xFFFF; assert rst mid-HOLD -> all outputs 0 immediately, no issued_en pulse.
